// File: rtl/trdb_instr_stage_if.sv
// Bundle between the instruction-stage history pipeline and its neighbours:
// retired-instruction fields and priority feedback in, lc/tc/nc qualifiers out.
interface trdb_instr_stage_if #(
  parameter int unsigned PRIV_W   = 2,
  parameter int unsigned CTX_W    = 32,
  parameter int unsigned OPMODE_W = 2
);
  logic                valid_i;
  logic                exception_i;
  logic                updiscon_i;
  logic                branch_i;
  logic                qualified_i;
  logic                trace_enable_i;
  logic [PRIV_W-1:0]   priv_i;
  logic [CTX_W-1:0]    context_i;
  logic [OPMODE_W-1:0] opmode_i;
  logic                packet_sent_i;
  logic                resync_rst_i;

  logic valid_o;
  logic lc_exception_o, lc_updiscon_o, lc_final_qualified_o;
  logic tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o;
  logic tc_privchange_o, tc_max_resync_o, tc_branch_map_empty_o, tc_branch_map_full_o;
  logic tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o;
  logic nc_exception_o, nc_privchange_o, nc_context_change_o, nc_branch_map_empty_o;
  logic nc_qualified_o, nc_retired_o;

  modport master (
    output valid_i, exception_i, updiscon_i, branch_i, qualified_i, trace_enable_i,
           priv_i, context_i, opmode_i, packet_sent_i, resync_rst_i,
    input  valid_o, lc_exception_o, lc_updiscon_o, lc_final_qualified_o,
           tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o,
           tc_privchange_o, tc_max_resync_o, tc_branch_map_empty_o, tc_branch_map_full_o,
           tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o,
           nc_exception_o, nc_privchange_o, nc_context_change_o, nc_branch_map_empty_o,
           nc_qualified_o, nc_retired_o
  );

  modport slave (
    input  valid_i, exception_i, updiscon_i, branch_i, qualified_i, trace_enable_i,
           priv_i, context_i, opmode_i, packet_sent_i, resync_rst_i,
    output valid_o, lc_exception_o, lc_updiscon_o, lc_final_qualified_o,
           tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o,
           tc_privchange_o, tc_max_resync_o, tc_branch_map_empty_o, tc_branch_map_full_o,
           tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o,
           nc_exception_o, nc_privchange_o, nc_context_change_o, nc_branch_map_empty_o,
           nc_qualified_o, nc_retired_o
  );
endinterface

// File: rtl/trdb_instr_stage.sv
// Three-deep retired-instruction history (next/this/last) feeding trdb_priority,
// plus the branch-map occupancy and resync counters.
module trdb_instr_stage #(
  parameter int unsigned          PRIV_W         = 2,
  parameter int unsigned          CTX_W          = 32,
  parameter int unsigned          OPMODE_W       = 2,
  parameter int unsigned          BRANCH_MAP_MAX = 31,
  parameter int unsigned          RESYNC_W       = 16,
  parameter logic [RESYNC_W-1:0]  MAX_RESYNC     = 16'hFFFF
) (
  input logic              clk_i,
  input logic              rst_i,
  trdb_instr_stage_if.slave bus
);
  localparam int unsigned BCNT_W = $clog2(BRANCH_MAP_MAX + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BRANCH_MAP_MAX);

  typedef struct packed {
    logic                occ;
    logic                exc;
    logic                upd;
    logic                br;
    logic                qual;
    logic                en;
    logic [PRIV_W-1:0]   priv;
    logic [CTX_W-1:0]    ctx;
    logic [OPMODE_W-1:0] opmode;
  } entry_t;

  entry_t                n_q, n_d, t_q, t_d, l_q, l_d, in_e;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [RESYNC_W-1:0]   rcnt_q, rcnt_d;
  logic                  valid_q, valid_d;
  logic                  br_inc;

  function automatic logic [BCNT_W-1:0] bcnt_sat_inc(input logic [BCNT_W-1:0] v);
    return (v == BCNT_MAX) ? v : v + BCNT_W'(1);
  endfunction

  function automatic logic [RESYNC_W-1:0] rcnt_sat_inc(input logic [RESYNC_W-1:0] v);
    return (v == MAX_RESYNC) ? v : v + RESYNC_W'(1);
  endfunction

  always_comb begin
    in_e        = '0;
    in_e.occ    = 1'b1;
    in_e.exc    = bus.exception_i;
    in_e.upd    = bus.updiscon_i;
    in_e.br     = bus.branch_i;
    in_e.qual   = bus.qualified_i & bus.trace_enable_i;
    in_e.en     = bus.trace_enable_i;
    in_e.priv   = bus.priv_i;
    in_e.ctx    = bus.context_i;
    in_e.opmode = bus.opmode_i;
  end

  // The branch counted is the one about to enter T, i.e. the current N.
  assign br_inc = bus.valid_i & n_q.occ & n_q.br;

  always_comb begin
    n_d     = n_q;
    t_d     = t_q;
    l_d     = l_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    valid_d = bus.valid_i & n_q.occ;
    if (bus.valid_i) begin
      l_d = t_q;
      t_d = n_q;
      n_d = in_e;
    end
    if (bus.packet_sent_i) begin
      bcnt_d = br_inc ? BCNT_W'(1) : '0;
    end else if (br_inc) begin
      bcnt_d = bcnt_sat_inc(bcnt_q);
    end
    if (bus.resync_rst_i) begin
      rcnt_d = '0;
    end else if (bus.valid_i) begin
      rcnt_d = rcnt_sat_inc(rcnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q     <= '0;
      t_q     <= '0;
      l_q     <= '0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      t_q     <= t_d;
      l_q     <= l_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
    end
  end

  // L's branch flag and context are never consulted once an entry ages out of T.
  logic unused_l;
  assign unused_l = ^{l_q.br, l_q.ctx};

  assign bus.valid_o               = valid_q;
  assign bus.lc_exception_o        = l_q.occ & l_q.exc;
  assign bus.lc_updiscon_o         = l_q.occ & l_q.upd;
  assign bus.lc_final_qualified_o  = l_q.occ & t_q.occ & l_q.qual & ~t_q.qual;

  assign bus.tc_qualified_o        = t_q.occ & t_q.qual;
  assign bus.tc_exception_o        = t_q.occ & t_q.exc;
  assign bus.tc_retired_o          = t_q.occ;
  assign bus.tc_first_qualified_o  = t_q.occ & t_q.qual & ~(l_q.occ & l_q.qual);
  assign bus.tc_privchange_o       = t_q.occ & l_q.occ & (t_q.priv != l_q.priv);
  assign bus.tc_max_resync_o       = (rcnt_q == MAX_RESYNC);
  assign bus.tc_branch_map_empty_o = (bcnt_q == '0);
  assign bus.tc_branch_map_full_o  = (bcnt_q == BCNT_MAX);
  assign bus.tc_enc_enabled_o      = t_q.occ & t_q.en & ~(l_q.occ & l_q.en);
  assign bus.tc_enc_disabled_o     = t_q.occ & l_q.occ & l_q.en & ~t_q.en;
  assign bus.tc_opmode_change_o    = t_q.occ & l_q.occ & (t_q.opmode != l_q.opmode);

  assign bus.nc_exception_o        = n_q.occ & n_q.exc;
  assign bus.nc_privchange_o       = n_q.occ & t_q.occ & (n_q.priv != t_q.priv);
  assign bus.nc_context_change_o   = n_q.occ & t_q.occ & (n_q.ctx != t_q.ctx);
  assign bus.nc_branch_map_empty_o = (bcnt_q == '0) & ~(n_q.occ & n_q.br);
  assign bus.nc_qualified_o        = n_q.occ & n_q.qual;
  assign bus.nc_retired_o          = n_q.occ;

endmodule

// File: tb/tb_trdb_instr_stage.sv
// Scoreboard bench for trdb_instr_stage: a history-list model predicts every
// output each cycle, plus directed checks of the documented scenarios.
module tb_trdb_instr_stage;
  localparam int MAXR = 4;
  localparam int BMAX = 31;

  localparam int B_VALID = 20, B_LCFQ = 17, B_TCFQ = 13, B_TCPC = 12, B_TCMAXR = 11;
  localparam int B_TCBME = 10, B_TCBMF = 9, B_TCEN = 8, B_TCDIS = 7, B_NCPC = 4, B_NCCC = 3;
  localparam logic [20:0] RESET_VEC = 21'h000404;

  typedef struct packed {
    logic        exc;
    logic        upd;
    logic        br;
    logic        q;
    logic        en;
    logic [1:0]  priv;
    logic [31:0] ctx;
    logic [1:0]  opm;
  } inst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trdb_instr_stage_if #(.PRIV_W(2), .CTX_W(32), .OPMODE_W(2)) bus ();

  trdb_instr_stage #(
    .PRIV_W(2), .CTX_W(32), .OPMODE_W(2), .BRANCH_MAP_MAX(BMAX),
    .RESYNC_W(16), .MAX_RESYNC(16'd4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [20:0] sb[$];
  logic [20:0] obs;

  inst_t hist[$];
  int    m_bcnt = 0;
  int    m_rcnt = 0;
  bit    m_vld  = 1'b0;

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {bus.valid_o, bus.lc_exception_o, bus.lc_updiscon_o, bus.lc_final_qualified_o,
            bus.tc_qualified_o, bus.tc_exception_o, bus.tc_retired_o, bus.tc_first_qualified_o,
            bus.tc_privchange_o, bus.tc_max_resync_o, bus.tc_branch_map_empty_o,
            bus.tc_branch_map_full_o, bus.tc_enc_enabled_o, bus.tc_enc_disabled_o,
            bus.tc_opmode_change_o, bus.nc_exception_o, bus.nc_privchange_o,
            bus.nc_context_change_o, bus.nc_branch_map_empty_o, bus.nc_qualified_o,
            bus.nc_retired_o};
  endfunction

  function automatic inst_t mk(bit exc, bit upd, bit br, bit q, bit en,
                               int priv, int ctx, int opm);
    inst_t x;
    x.exc = exc; x.upd = upd; x.br = br; x.q = q; x.en = en;
    x.priv = 2'(priv); x.ctx = 32'(ctx); x.opm = 2'(opm);
    return x;
  endfunction

  function automatic logic [20:0] model_out();
    inst_t n = '0, t = '0, l = '0;
    bit no, to, lo, bme;
    no = hist.size() > 0;
    to = hist.size() > 1;
    lo = hist.size() > 2;
    if (no) n = hist[0];
    if (to) t = hist[1];
    if (lo) l = hist[2];
    bme = (m_bcnt == 0);
    return {m_vld, lo & l.exc, lo & l.upd, lo & to & l.q & !t.q,
            to & t.q, to & t.exc, to, to & t.q & !(lo & l.q),
            to & lo & (t.priv != l.priv), m_rcnt == MAXR, bme, m_bcnt == BMAX,
            to & t.en & !(lo & l.en), lo & to & l.en & !t.en, to & lo & (t.opm != l.opm),
            no & n.exc, no & to & (n.priv != t.priv), no & to & (n.ctx != t.ctx),
            bme & !(no & n.br), no & n.q, no};
  endfunction

  task automatic model_step(input inst_t x, input bit v, input bit ps, input bit rr);
    bit inc;
    inst_t s;
    inc   = v && hist.size() > 0 && hist[0].br;
    m_vld = v && hist.size() > 0;
    if (ps) m_bcnt = inc ? 1 : 0;
    else if (inc && m_bcnt < BMAX) m_bcnt++;
    if (rr) m_rcnt = 0;
    else if (v && m_rcnt < MAXR) m_rcnt++;
    if (v) begin
      s   = x;
      s.q = x.q & x.en;
      hist.push_front(s);
      if (hist.size() > 3) void'(hist.pop_back());
    end
  endtask

  task automatic step(input string tag, input inst_t x, input bit v, input bit ps, input bit rr);
    bus.valid_i        = v;
    bus.exception_i    = x.exc;
    bus.updiscon_i     = x.upd;
    bus.branch_i       = x.br;
    bus.qualified_i    = x.q;
    bus.trace_enable_i = x.en;
    bus.priv_i         = x.priv;
    bus.context_i      = x.ctx;
    bus.opmode_i       = x.opm;
    bus.packet_sent_i  = ps;
    bus.resync_rst_i   = rr;
    model_step(x, v, ps, rr);
    sb.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    obs = dut_vec();
    if (sb.size() == 0) chk({tag, "_sb_empty"}, obs, 21'h1FFFFF);
    else chk(tag, obs, sb.pop_front());
  endtask

  task automatic do_reset(input string tag);
    bus.valid_i       = 1'b0;
    bus.packet_sent_i = 1'b0;
    bus.resync_rst_i  = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_async"}, dut_vec(), RESET_VEC);
    hist.delete();
    m_bcnt = 0; m_rcnt = 0; m_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_held"}, dut_vec(), RESET_VEC);
    rst = 1'b0;
  endtask

  initial begin
    inst_t x;
    bus.valid_i = 1'b0; bus.exception_i = 1'b0; bus.updiscon_i = 1'b0;
    bus.branch_i = 1'b0; bus.qualified_i = 1'b0; bus.trace_enable_i = 1'b0;
    bus.priv_i = '0; bus.context_i = '0; bus.opmode_i = '0;
    bus.packet_sent_i = 1'b0; bus.resync_rst_i = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // Fill and latency
    x = mk(0, 0, 0, 1, 1, 3, 5, 0);
    step("fill_A", x, 1, 0, 0);
    chk("first_valid_no_vo", 21'(obs[B_VALID]), 21'd0);
    step("fill_B", x, 1, 0, 0);
    chk("fill_B_vo", 21'(obs[B_VALID]), 21'd1);
    chk("fill_B_fq", 21'(obs[B_TCFQ]), 21'd1);
    step("fill_C", x, 1, 0, 0);
    chk("fill_C_vo", 21'(obs[B_VALID]), 21'd1);
    chk("fill_C_fq", 21'(obs[B_TCFQ]), 21'd0);
    for (int i = 0; i < 3; i++) begin
      step("idle", '0, 0, 0, 0);
      chk("idle_vo", 21'(obs[B_VALID]), 21'd0);
    end

    // Privilege and context change
    step("priv_X", mk(0, 0, 0, 1, 1, 3, 5, 0), 1, 0, 0);
    step("priv_Y", mk(0, 0, 0, 1, 1, 3, 5, 0), 1, 0, 0);
    step("priv_Z", mk(0, 0, 0, 1, 1, 1, 5, 0), 1, 0, 0);
    chk("nc_privchange", 21'(obs[B_NCPC]), 21'd1);
    step("priv_W", mk(0, 0, 0, 1, 1, 1, 5, 0), 1, 0, 0);
    chk("tc_privchange", 21'(obs[B_TCPC]), 21'd1);
    chk("nc_ctx_before", 21'(obs[B_NCCC]), 21'd0);
    step("ctx_V", mk(0, 0, 0, 1, 1, 1, 6, 0), 1, 0, 0);
    chk("nc_ctxchange", 21'(obs[B_NCCC]), 21'd1);
    do_reset("rst_mid");

    // Branch map saturation and packet_sent coinciding with a branch shift
    for (int i = 1; i <= 33; i++) begin
      step("br_fill", mk(0, 0, 1, 1, 1, 0, 0, 0), 1, 0, 0);
      if (i == 31) chk("br_not_full_30", 21'(obs[B_TCBMF]), 21'd0);
      if (i == 32) chk("br_full_31", 21'(obs[B_TCBMF]), 21'd1);
    end
    chk("br_full_sat", 21'(obs[B_TCBMF]), 21'd1);
    step("br_pkt", mk(0, 0, 1, 1, 1, 0, 0, 0), 1, 1, 0);
    chk("br_pkt_empty", 21'(obs[B_TCBME]), 21'd0);
    chk("br_pkt_full", 21'(obs[B_TCBMF]), 21'd0);
    do_reset("rst_br");

    // Resync
    for (int i = 1; i <= 4; i++) begin
      step("rs_fill", mk(0, 0, 0, 1, 1, 0, 0, 0), 1, 0, 0);
      if (i == 3) chk("rs_not_max", 21'(obs[B_TCMAXR]), 21'd0);
    end
    chk("rs_max", 21'(obs[B_TCMAXR]), 21'd1);
    step("rs_clr", mk(0, 0, 0, 1, 1, 0, 0, 0), 1, 0, 1);
    chk("rs_clr_wins", 21'(obs[B_TCMAXR]), 21'd0);
    do_reset("rst_rs");

    // Enable and disable
    step("en_1", mk(0, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0);
    step("en_2", mk(0, 0, 0, 1, 1, 0, 0, 0), 1, 0, 0);
    step("en_3", mk(0, 0, 0, 1, 1, 0, 0, 0), 1, 0, 0);
    chk("tc_enc_enabled", 21'(obs[B_TCEN]), 21'd1);
    step("en_4", mk(0, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0);
    step("en_5", mk(0, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0);
    chk("tc_enc_disabled", 21'(obs[B_TCDIS]), 21'd1);
    chk("lc_final_qual", 21'(obs[B_LCFQ]), 21'd1);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      x = mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
      step("rand", x, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "bench timeout");
  end
endmodule
